// File: rtl/lock_io_pkg.sv
// Shared definitions for the canal-lock input front end: input index names,
// default timing constants and a counter-width helper.
package lock_io_pkg;

  typedef enum logic [1:0] {
    ARR   = 2'd0,
    DEP   = 2'd1,
    GATE1 = 2'd2,
    GATE2 = 2'd3
  } sw_idx_e;

  typedef enum logic [0:0] {
    W_UP   = 1'b0,
    W_DOWN = 1'b1
  } key_idx_e;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_TICK_DIV        = 8388608;
  localparam int DEF_REPEAT_TICKS    = 4;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// Two-flop synchroniser followed by a stability counter: the clean level only
// follows the synchronised input after DEBOUNCE_CYCLES consecutive differing
// samples; any sample equal to the current clean level restarts the count.
module debounce_cell
  import lock_io_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic clean_o
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          clean_q;
  logic          clean_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next-state for the stability counter and the accepted clean level.
  always_comb begin
    clean_d = clean_q;
    cnt_d   = cnt_q;
    if (sync2_q == clean_q) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q == CNT_LAST) begin
      clean_d = sync2_q;
      cnt_d   = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Synchroniser pair, counter and clean flop; reset discards any progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
      clean_q <= RESET_VAL;
      cnt_q   <= {CW{1'b0}};
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clean_o = clean_q;

endmodule

// File: rtl/lock_input_conditioner.sv
// Front end for the canal-lock controller: debounced switch levels, active-high
// key levels, a slow one-cycle tick, and sticky per-key press events that are
// consumed by a tick, with auto-repeat while a key stays held.
module lock_input_conditioner
  import lock_io_pkg::*;
#(
  parameter int N_SW            = 4,
  parameter int N_KEY           = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TICK_DIV        = DEF_TICK_DIV,
  parameter int REPEAT_TICKS    = DEF_REPEAT_TICKS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SW-1:0]  sw_raw,
  input  logic [N_KEY-1:0] key_raw,
  output logic             tick,
  output logic [N_SW-1:0]  sw_clean,
  output logic [N_KEY-1:0] key_level,
  output logic [N_KEY-1:0] key_press
);

  localparam int            TW        = cnt_width(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [N_KEY-1:0] key_clean_s;
  logic [TW-1:0]    tick_cnt_q;
  logic [TW-1:0]    tick_cnt_d;
  logic             tick_q;
  logic             tick_d;
  logic [N_KEY-1:0] level_prev_q;
  logic [N_KEY-1:0] press_q;
  logic [N_KEY-1:0] press_d;
  logic [N_KEY-1:0] rise_s;
  logic [N_KEY-1:0] rpt_hit_s;
  logic [N_KEY-1:0] set_s;

  for (genvar gi = 0; gi < N_SW; gi++) begin : g_sw
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (1'b0)
    ) u_db (
      .clk    (clk),
      .rst_n  (reset),
      .raw_i  (sw_raw[gi]),
      .clean_o(sw_clean[gi])
    );
  end

  // Keys idle high (released), so their cells reset to 1.
  for (genvar gk = 0; gk < N_KEY; gk++) begin : g_key
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (1'b1)
    ) u_db (
      .clk    (clk),
      .rst_n  (reset),
      .raw_i  (key_raw[gk]),
      .clean_o(key_clean_s[gk])
    );
  end

  assign key_level = ~key_clean_s;

  // Free-running divider; the tick flop fires the cycle after the last count.
  always_comb begin
    if (tick_cnt_q == TICK_LAST) begin
      tick_cnt_d = {TW{1'b0}};
      tick_d     = 1'b1;
    end else begin
      tick_cnt_d = tick_cnt_q + TW'(1);
      tick_d     = 1'b0;
    end
  end

  // Divider count and registered tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= {TW{1'b0}};
      tick_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
    end
  end

  assign tick = tick_q;

  if (REPEAT_TICKS > 0) begin : g_rpt
    localparam int            RW       = cnt_width(REPEAT_TICKS);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_TICKS - 1);

    logic [N_KEY-1:0][RW-1:0] rpt_q;
    logic [N_KEY-1:0][RW-1:0] rpt_d;

    // Count ticks while a key is held; every REPEAT_TICKS-th tick re-arms the press.
    always_comb begin
      rpt_d     = rpt_q;
      rpt_hit_s = {N_KEY{1'b0}};
      for (int i = 0; i < N_KEY; i++) begin
        if (!key_level[i]) begin
          rpt_d[i] = {RW{1'b0}};
        end else if (tick_q) begin
          if (rpt_q[i] == RPT_LAST) begin
            rpt_hit_s[i] = 1'b1;
            rpt_d[i]     = {RW{1'b0}};
          end else begin
            rpt_d[i] = rpt_q[i] + RW'(1);
          end
        end else begin
          rpt_d[i] = rpt_q[i];
        end
      end
    end

    // Per-key repeat counters.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rpt_q <= '{default: {RW{1'b0}}};
      end else begin
        rpt_q <= rpt_d;
      end
    end
  end else begin : g_no_rpt
    assign rpt_hit_s = {N_KEY{1'b0}};
  end

  // A new press or repeat wins over the tick that would otherwise consume it.
  always_comb begin
    rise_s  = key_level & ~level_prev_q;
    set_s   = rise_s | rpt_hit_s;
    press_d = set_s | (press_q & ~{N_KEY{tick_q}});
  end

  // Edge-detect history and sticky press flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_prev_q <= {N_KEY{1'b0}};
      press_q      <= {N_KEY{1'b0}};
    end else begin
      level_prev_q <= key_level;
      press_q      <= press_d;
    end
  end

  assign key_press = press_q;

endmodule

// File: tb/tb_lock_input_conditioner.sv
// Self-checking bench for lock_input_conditioner with short timing parameters.
module tb_lock_input_conditioner;

  localparam int BD = 4;   // debounce cycles
  localparam int BT = 8;   // tick period
  localparam int BR = 2;   // repeat ticks

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] sw_raw = 4'b0000;
  logic [1:0] key_raw = 2'b11;
  logic       tick;
  logic [3:0] sw_clean;
  logic [1:0] key_level;
  logic [1:0] key_press;

  int n_checks = 0;
  int n_errors = 0;

  lock_input_conditioner #(
    .N_SW(4), .N_KEY(2), .DEBOUNCE_CYCLES(BD), .TICK_DIV(BT), .REPEAT_TICKS(BR)
  ) dut (
    .clk(clk), .reset(reset), .sw_raw(sw_raw), .key_raw(key_raw),
    .tick(tick), .sw_clean(sw_clean), .key_level(key_level), .key_press(key_press)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Inputs packed as {key_raw, sw_raw}; a raw value becomes visible two
  // edges after it is sampled, and the clean level flips once the last BD
  // visible samples all disagree with it.
  logic [5:0] m_s1, m_s2, m_clean;
  logic [BD-1:0] m_hist [6];
  int   m_ecount;
  logic m_tick;
  logic [1:0] m_lvl_prev, m_press;
  int   m_held [2];
  logic [1:0] lvl_now_m, ev_m;
  logic tick_now_m;
  localparam logic [5:0] IDLE6 = 6'b110000;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_s1 = IDLE6; m_s2 = IDLE6; m_clean = IDLE6;
      for (int i = 0; i < 6; i++) m_hist[i] = {BD{IDLE6[i]}};
      m_ecount = 0; m_tick = 1'b0; m_lvl_prev = 2'b00; m_press = 2'b00;
      m_held[0] = 0; m_held[1] = 0;
    end else begin
      lvl_now_m  = ~m_clean[5:4];
      tick_now_m = m_tick;
      for (int k = 0; k < 2; k++) begin
        ev_m[k] = lvl_now_m[k] & ~m_lvl_prev[k];
        if (!lvl_now_m[k]) m_held[k] = 0;
        else if (tick_now_m) begin
          m_held[k] = m_held[k] + 1;
          if (m_held[k] % BR == 0) ev_m[k] = 1'b1;
        end
        if (ev_m[k]) m_press[k] = 1'b1;
        else if (tick_now_m) m_press[k] = 1'b0;
      end
      m_lvl_prev = lvl_now_m;
      m_ecount = m_ecount + 1;
      m_tick = (m_ecount % BT == 0);
      for (int i = 0; i < 6; i++) begin
        m_hist[i] = {m_hist[i][BD-2:0], m_s2[i]};
        if (m_hist[i] == {BD{~m_clean[i]}}) m_clean[i] = ~m_clean[i];
      end
      m_s2 = m_s1;
      m_s1 = {key_raw, sw_raw};
    end
  end

  logic [8:0] exp_v, act_v;
  assign exp_v = {m_tick, m_clean[3:0], ~m_clean[5:4], m_press};
  assign act_v = {tick, sw_clean, key_level, key_press};

  // ---------------- tests ----------------
  task automatic test_reset();
    int first, second;
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      sw_raw = 4'($urandom); key_raw = 2'($urandom);
      n_checks++;
      if (act_v !== 9'd0) begin n_errors++; $display("FAIL reset_hold got %b exp %b", act_v, 9'd0); end
    end
    sw_raw = 4'b0000; key_raw = 2'b11;
    @(negedge clk); reset = 1'b1;
    first = 0; second = 0;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      if (tick === 1'b1) begin
        if (first == 0) first = e; else if (second == 0) second = e;
      end
      n_checks++;
      if (act_v !== exp_v) begin n_errors++; $display("FAIL reset_model e=%0d got %b exp %b", e, act_v, exp_v); end
    end
    n_checks++;
    if (first != 8) begin n_errors++; $display("FAIL first_tick got %0d exp 8", first); end
    n_checks++;
    if (second != 16) begin n_errors++; $display("FAIL second_tick got %0d exp 16", second); end
  endtask

  task automatic test_clean_switch();
    @(negedge clk); sw_raw[0] = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      n_checks++;
      if (sw_clean[0] !== (j >= 5)) begin n_errors++; $display("FAIL clean_sw j=%0d got %b exp %b", j, sw_clean[0], (j >= 5)); end
      n_checks++;
      if (act_v !== exp_v) begin n_errors++; $display("FAIL clean_model j=%0d got %b exp %b", j, act_v, exp_v); end
    end
  endtask

  task automatic test_bounce();
    int trans, at;
    logic prev;
    @(negedge clk); sw_raw[2] = 1'b1;
    @(negedge clk); sw_raw[2] = 1'b0;
    @(negedge clk); sw_raw[2] = 1'b1;
    prev = sw_clean[2]; trans = 0; at = -1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (sw_clean[2] !== prev) begin trans++; if (at < 0) at = j; prev = sw_clean[2]; end
      n_checks++;
      if (act_v !== exp_v) begin n_errors++; $display("FAIL bounce_model j=%0d got %b exp %b", j, act_v, exp_v); end
    end
    n_checks++;
    if (trans != 1) begin n_errors++; $display("FAIL bounce_trans got %0d exp 1", trans); end
    n_checks++;
    if (at != 5) begin n_errors++; $display("FAIL bounce_time got %0d exp 5", at); end
  endtask

  task automatic test_press();
    int dut_rises, mdl_rises;
    logic dp, mp;
    @(negedge clk); key_raw[0] = 1'b0;
    dut_rises = 0; mdl_rises = 0; dp = key_press[0]; mp = m_press[0];
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (key_press[0] === 1'b1 && dp !== 1'b1) dut_rises++;
      if (m_press[0] && !mp) mdl_rises++;
      dp = key_press[0]; mp = m_press[0];
      n_checks++;
      if (act_v !== exp_v) begin n_errors++; $display("FAIL press_model j=%0d got %b exp %b", j, act_v, exp_v); end
    end
    n_checks++;
    if (dut_rises != mdl_rises) begin n_errors++; $display("FAIL press_events got %0d exp %0d", dut_rises, mdl_rises); end
    key_raw[0] = 1'b1;
    repeat (16) begin
      @(negedge clk);
      n_checks++;
      if (act_v !== exp_v) begin n_errors++; $display("FAIL release_model got %b exp %b", act_v, exp_v); end
    end
    dut_rises = 0;
    repeat (32) begin
      @(negedge clk);
      if (key_press[0] === 1'b1) dut_rises++;
    end
    n_checks++;
    if (dut_rises != 0) begin n_errors++; $display("FAIL press_after_release got %0d exp 0", dut_rises); end
  endtask

  task automatic test_collision();
    int guard;
    int seen;
    guard = 0;
    do begin @(negedge clk); guard++; end while ((m_ecount % BT) != 2 && guard < 20);
    key_raw[1] = 1'b0;
    seen = 0;
    for (int j = 0; j < 10 && seen == 0; j++) begin
      @(negedge clk);
      if (key_level[1] === 1'b1) seen = 1;
    end
    n_checks++;
    if (seen != 1) begin n_errors++; $display("FAIL collision_level got %0d exp 1", seen); end
    n_checks++;
    if (tick !== 1'b1) begin n_errors++; $display("FAIL collision_tick got %b exp 1", tick); end
    key_raw[1] = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      n_checks++;
      if (key_press[1] !== (j <= 8)) begin n_errors++; $display("FAIL collision_press j=%0d got %b exp %b", j, key_press[1], (j <= 8)); end
      n_checks++;
      if (act_v !== exp_v) begin n_errors++; $display("FAIL collision_model j=%0d got %b exp %b", j, act_v, exp_v); end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int bad;
    // mid-debounce: raw sampled at edge k, counter at 2 after edge k+3
    @(negedge clk); key_raw[0] = 1'b0; sw_raw[1] = 1'b1;
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (act_v !== 9'd0) begin n_errors++; $display("FAIL reset_mid_db got %b exp %b", act_v, 9'd0); end
    key_raw = 2'b11; sw_raw = 4'b0000;
    @(negedge clk); reset = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (key_press !== 2'b00) bad++;
      n_checks++;
      if (act_v !== exp_v) begin n_errors++; $display("FAIL reset_mid_db_model got %b exp %b", act_v, exp_v); end
    end
    n_checks++;
    if (bad != 0) begin n_errors++; $display("FAIL spurious_press_db got %0d exp 0", bad); end
    // mid-repeat
    key_raw[0] = 1'b0;
    repeat (20) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (act_v !== 9'd0) begin n_errors++; $display("FAIL reset_mid_rpt got %b exp %b", act_v, 9'd0); end
    key_raw = 2'b11;
    @(negedge clk); reset = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (key_press !== 2'b00) bad++;
      n_checks++;
      if (act_v !== exp_v) begin n_errors++; $display("FAIL reset_mid_rpt_model got %b exp %b", act_v, exp_v); end
    end
    n_checks++;
    if (bad != 0) begin n_errors++; $display("FAIL spurious_press_rpt got %0d exp 0", bad); end
  endtask

  task automatic test_random();
    logic [5:0] raw6;
    raw6 = {key_raw, sw_raw};
    for (int j = 0; j < 800; j++) begin
      @(negedge clk);
      n_checks++;
      if (act_v !== exp_v) begin n_errors++; $display("FAIL random j=%0d got %b exp %b", j, act_v, exp_v); end
      if ($urandom_range(0, 3) == 0) begin
        raw6[$urandom_range(0, 5)] ^= 1'b1;
        sw_raw = raw6[3:0]; key_raw = raw6[5:4];
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_switch();
    test_bounce();
    test_press();
    test_collision();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
